// File: rtl/mips_cache_pkg.sv
// mips_cache_pkg: cache state type, block geometry and address field helpers shared by the caches
package mips_cache_pkg;

    typedef enum logic {IDLE, FILL} cache_state_e;

    localparam int BLOCK_BITS      = 256;
    localparam int WORDS_PER_BLOCK = 8;
    localparam int OFFSET_W        = 5;

    function automatic logic [2:0] addr_word(input logic [31:0] a);
        return a[4:2];
    endfunction

    function automatic logic [31:0] addr_index(input logic [31:0] a, input int idx_w);
        return (a >> OFFSET_W) & ((32'd1 << idx_w) - 32'd1);
    endfunction

    function automatic logic [31:0] addr_tag(input logic [31:0] a, input int idx_w);
        return a >> (OFFSET_W + idx_w);
    endfunction

    function automatic logic [31:0] block_addr(input logic [31:0] a);
        return {a[31:OFFSET_W], {OFFSET_W{1'b0}}};
    endfunction

endpackage

// File: rtl/icache_tag_array.sv
// icache_tag_array: per-line valid bits and tags with one lookup port, one write port and bulk invalidate
module icache_tag_array #(
    parameter int NUM_LINES = 64,
    parameter int IDX_W     = 6,
    parameter int TAG_W     = 21
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [IDX_W-1:0] i_lookup_idx,
    input  logic [TAG_W-1:0] i_lookup_tag,
    output logic             o_hit,
    input  logic             i_wr_en,
    input  logic [IDX_W-1:0] i_wr_idx,
    input  logic [TAG_W-1:0] i_wr_tag,
    input  logic             i_wr_valid,
    input  logic             i_inv_all
);

    logic [NUM_LINES-1:0] r_valid;
    logic [TAG_W-1:0]     r_tag [NUM_LINES];

    assign o_hit = r_valid[i_lookup_idx] && (r_tag[i_lookup_idx] == i_lookup_tag);

    // valid bits: bulk invalidate takes priority over a line install
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_valid <= '0;
        else if (i_inv_all)
            r_valid <= '0;
        else if (i_wr_en)
            r_valid[i_wr_idx] <= i_wr_valid;
    end

    // tag storage is not reset; the valid bit guards it
    always_ff @(posedge clk) begin
        if (i_wr_en)
            r_tag[i_wr_idx] <= i_wr_tag;
    end

endmodule

// File: rtl/icache_direct_mapped.sv
// icache_direct_mapped: direct-mapped read-only instruction cache with block fill from instruction memory
module icache_direct_mapped
    import mips_cache_pkg::*;
#(
    parameter int NUM_LINES = 64,
    parameter int IDX_W     = 6
) (
    input  logic                  CLK,
    input  logic                  RESET,
    input  logic [31:0]           Instr_address_2IC,
    input  logic                  Invalidate,
    output logic [31:0]           Instr1_fIC,
    output logic [31:0]           Instr2_fIC,
    output logic                  Instr1_valid_fIC,
    output logic                  Instr2_valid_fIC,
    output logic                  STALL_fIC,
    output logic [31:0]           Instr_address_2IM,
    output logic                  iBlkRead,
    input  logic [BLOCK_BITS-1:0] block_read_fIM,
    input  logic                  block_read_fIM_valid,
    output logic [31:0]           HitCount,
    output logic [31:0]           MissCount
);

    localparam int TAG_W = 32 - OFFSET_W - IDX_W;

    cache_state_e          r_state, w_next;
    logic [31:0]           r_miss_addr;
    logic                  r_fill_inv;
    logic [31:0]           r_hit_cnt, r_miss_cnt;
    logic [BLOCK_BITS-1:0] r_data [NUM_LINES];

    logic [IDX_W-1:0]      w_idx, w_miss_idx;
    logic [TAG_W-1:0]      w_tag, w_miss_tag;
    logic [2:0]            w_word, w_word2;
    logic [BLOCK_BITS-1:0] w_line;
    logic                  w_lookup_hit, w_hit, w_miss, w_fill_done, w_last_word;

    assign w_idx       = IDX_W'(addr_index(Instr_address_2IC, IDX_W));
    assign w_tag       = TAG_W'(addr_tag(Instr_address_2IC, IDX_W));
    assign w_miss_idx  = IDX_W'(addr_index(r_miss_addr, IDX_W));
    assign w_miss_tag  = TAG_W'(addr_tag(r_miss_addr, IDX_W));
    assign w_word      = addr_word(Instr_address_2IC);
    assign w_word2     = w_word + 3'd1;
    assign w_last_word = (w_word == 3'(WORDS_PER_BLOCK - 1));
    assign w_line      = r_data[w_idx];

    assign w_hit       = (r_state == IDLE) && w_lookup_hit;
    assign w_miss      = (r_state == IDLE) && !w_lookup_hit;
    assign w_fill_done = (r_state == FILL) && block_read_fIM_valid;

    icache_tag_array #(
        .NUM_LINES (NUM_LINES),
        .IDX_W     (IDX_W),
        .TAG_W     (TAG_W)
    ) u_tags (
        .clk          (CLK),
        .rst_n        (RESET),
        .i_lookup_idx (w_idx),
        .i_lookup_tag (w_tag),
        .o_hit        (w_lookup_hit),
        .i_wr_en      (w_fill_done),
        .i_wr_idx     (w_miss_idx),
        .i_wr_tag     (w_miss_tag),
        .i_wr_valid   (!r_fill_inv),
        .i_inv_all    (Invalidate)
    );

    // next state: a miss starts a fill, fill data returns to lookup
    always_comb begin
        w_next = r_state;
        if (w_miss)
            w_next = FILL;
        else if (w_fill_done)
            w_next = IDLE;
    end

    // state, miss address, pending-invalidate flag and saturating counters
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            r_state     <= IDLE;
            r_miss_addr <= '0;
            r_fill_inv  <= 1'b0;
            r_hit_cnt   <= '0;
            r_miss_cnt  <= '0;
        end else begin
            r_state    <= w_next;
            r_fill_inv <= (r_state == FILL) && !block_read_fIM_valid && (r_fill_inv || Invalidate);
            if (w_miss)
                r_miss_addr <= Instr_address_2IC;
            if (w_hit && r_hit_cnt != '1)
                r_hit_cnt <= r_hit_cnt + 32'd1;
            if (w_miss && r_miss_cnt != '1)
                r_miss_cnt <= r_miss_cnt + 32'd1;
        end
    end

    // data array is written only when a fill returns; contents are not reset
    always_ff @(posedge CLK) begin
        if (w_fill_done)
            r_data[w_miss_idx] <= block_read_fIM;
    end

    assign Instr1_fIC        = w_line[{w_word, 5'b0} +: 32];
    assign Instr2_fIC        = w_last_word ? '0 : w_line[{w_word2, 5'b0} +: 32];
    assign Instr1_valid_fIC  = w_hit;
    assign Instr2_valid_fIC  = w_hit && !w_last_word;
    assign STALL_fIC         = !w_hit;
    assign Instr_address_2IM = block_addr((r_state == FILL) ? r_miss_addr : Instr_address_2IC);
    assign iBlkRead          = (r_state == FILL);
    assign HitCount          = r_hit_cnt;
    assign MissCount         = r_miss_cnt;

endmodule

// File: tb/tb_icache_direct_mapped.sv
// tb_icache_direct_mapped: table-driven fetch sequence with a fill responder and an expected-output queue
module tb_icache_direct_mapped;

    localparam int LAT = 3;

    logic         CLK = 1'b0;
    logic         RESET = 1'b0;
    logic [31:0]  Instr_address_2IC = '0;
    logic         Invalidate = 1'b0;
    logic [31:0]  Instr1_fIC, Instr2_fIC;
    logic         Instr1_valid_fIC, Instr2_valid_fIC, STALL_fIC;
    logic [31:0]  Instr_address_2IM;
    logic         iBlkRead;
    logic [255:0] block_read_fIM = '0;
    logic         block_read_fIM_valid = 1'b0;
    logic [31:0]  HitCount, MissCount;

    int n_chk = 0;
    int n_fail = 0;

    typedef struct {
        logic [31:0] i1;
        logic [31:0] i2;
        logic        i2v;
    } exp_t;

    typedef struct {
        logic [31:0] addr;
        bit          miss;
        logic [31:0] hits;
        logic [31:0] misses;
    } vec_t;

    exp_t sb[$];
    vec_t tbl[13];

    icache_direct_mapped dut (
        .CLK                  (CLK),
        .RESET                (RESET),
        .Instr_address_2IC    (Instr_address_2IC),
        .Invalidate           (Invalidate),
        .Instr1_fIC           (Instr1_fIC),
        .Instr2_fIC           (Instr2_fIC),
        .Instr1_valid_fIC     (Instr1_valid_fIC),
        .Instr2_valid_fIC     (Instr2_valid_fIC),
        .STALL_fIC            (STALL_fIC),
        .Instr_address_2IM    (Instr_address_2IM),
        .iBlkRead             (iBlkRead),
        .block_read_fIM       (block_read_fIM),
        .block_read_fIM_valid (block_read_fIM_valid),
        .HitCount             (HitCount),
        .MissCount            (MissCount)
    );

    always #5 CLK = ~CLK;

    function automatic logic [31:0] mk_word(input logic [31:0] a);
        return {a[31:2], 2'b00} ^ 32'hC0DE_0000;
    endfunction

    function automatic logic [255:0] mk_block(input logic [31:0] blk);
        logic [255:0] b;
        for (int w = 0; w < 8; w++)
            b[32*w +: 32] = mk_word({blk[31:5], 5'b0} + 32'(4 * w));
        return b;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Serve one block read for blk; optionally pulse Invalidate in the first fill cycle.
    task automatic run_fill(input logic [31:0] blk, input bit inv);
        int w = 0;
        while (!iBlkRead && w < 10) begin
            @(negedge CLK);
            #1;
            w++;
        end
        chk("fill_start", {31'b0, iBlkRead}, 32'd1);
        for (int c = 1; c <= LAT; c++) begin
            chk("fill_addr", Instr_address_2IM, blk);
            Invalidate = inv && (c == 1);
            if (c == LAT) begin
                block_read_fIM = mk_block(blk);
                block_read_fIM_valid = 1'b1;
            end
            @(negedge CLK);
            Invalidate = 1'b0;
            block_read_fIM_valid = 1'b0;
            #1;
        end
    endtask

    // Present an address, act as instruction memory until it hits, then check the hit outputs.
    task automatic fetch(input logic [31:0] a, input bit miss);
        int   stalls = 0;
        int   cnt = 0;
        exp_t e;
        e.i1  = mk_word(a);
        e.i2v = (a[4:2] != 3'd7);
        e.i2  = e.i2v ? mk_word(a + 32'd4) : 32'd0;
        sb.push_back(e);
        Instr_address_2IC = a;
        #1;
        while (!Instr1_valid_fIC && stalls < 40) begin
            if (iBlkRead) begin
                cnt++;
                chk("miss_addr", Instr_address_2IM, {a[31:5], 5'b0});
                if (cnt == LAT) begin
                    block_read_fIM = mk_block(Instr_address_2IM);
                    block_read_fIM_valid = 1'b1;
                end
            end
            @(negedge CLK);
            block_read_fIM_valid = 1'b0;
            #1;
            stalls++;
        end
        chk("stall_cycles", 32'(stalls), miss ? 32'(LAT + 1) : 32'd0);
        chk("hit_stall", {31'b0, STALL_fIC}, 32'd0);
        chk("idle_im_addr", Instr_address_2IM, {a[31:5], 5'b0});
        e = sb.pop_front();
        chk("instr1", Instr1_fIC, e.i1);
        chk("instr2_valid", {31'b0, Instr2_valid_fIC}, {31'b0, e.i2v});
        chk("instr2", Instr2_fIC, e.i2);
        @(negedge CLK);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        tbl[0]  = '{32'h0040_0000, 1'b1, 32'd1,  32'd1};
        tbl[1]  = '{32'h0040_0004, 1'b0, 32'd2,  32'd1};
        tbl[2]  = '{32'h0040_0008, 1'b0, 32'd3,  32'd1};
        tbl[3]  = '{32'h0040_000C, 1'b0, 32'd4,  32'd1};
        tbl[4]  = '{32'h0040_0010, 1'b0, 32'd5,  32'd1};
        tbl[5]  = '{32'h0040_0014, 1'b0, 32'd6,  32'd1};
        tbl[6]  = '{32'h0040_0018, 1'b0, 32'd7,  32'd1};
        tbl[7]  = '{32'h0040_001C, 1'b0, 32'd8,  32'd1};
        tbl[8]  = '{32'h0040_0800, 1'b1, 32'd9,  32'd2};
        tbl[9]  = '{32'h0040_0000, 1'b1, 32'd10, 32'd3};
        tbl[10] = '{32'h0040_0020, 1'b1, 32'd11, 32'd4};
        tbl[11] = '{32'h0040_0024, 1'b0, 32'd12, 32'd4};
        tbl[12] = '{32'h0040_0000, 1'b0, 32'd13, 32'd4};

        repeat (2) @(negedge CLK);
        #1;
        chk("rst_stall", {31'b0, STALL_fIC}, 32'd1);
        chk("rst_i1_valid", {31'b0, Instr1_valid_fIC}, 32'd0);
        chk("rst_blkread", {31'b0, iBlkRead}, 32'd0);
        chk("rst_hits", HitCount, 32'd0);
        chk("rst_misses", MissCount, 32'd0);
        RESET = 1'b1;
        Instr_address_2IC = 32'h0040_0000;
        #1;
        chk("cold_stall", {31'b0, STALL_fIC}, 32'd1);

        for (int i = 0; i < 13; i++) begin
            fetch(tbl[i].addr, tbl[i].miss);
            chk("hit_count", HitCount, tbl[i].hits);
            chk("miss_count", MissCount, tbl[i].misses);
        end

        Instr_address_2IC = 32'h0040_0100;
        @(negedge CLK);
        #1;
        chk("mid_fill_blkread", {31'b0, iBlkRead}, 32'd1);
        Instr_address_2IC = 32'h0040_0200;
        #1;
        chk("mid_fill_addr_hold", Instr_address_2IM, 32'h0040_0100);
        run_fill(32'h0040_0100, 1'b0);
        chk("after_fill_stall", {31'b0, STALL_fIC}, 32'd1);
        chk("after_fill_im_addr", Instr_address_2IM, 32'h0040_0200);
        chk("after_fill_blkread", {31'b0, iBlkRead}, 32'd0);
        fetch(32'h0040_0200, 1'b1);
        fetch(32'h0040_0104, 1'b0);

        Instr_address_2IC = 32'h0040_0300;
        #1;
        run_fill(32'h0040_0300, 1'b1);
        chk("inv_fill_not_valid", {31'b0, STALL_fIC}, 32'd1);
        fetch(32'h0040_0300, 1'b1);
        fetch(32'h0040_0000, 1'b1);
        #1;
        Invalidate = 1'b1;
        #1;
        chk("inv_same_cycle_hit", {31'b0, Instr1_valid_fIC}, 32'd1);
        @(negedge CLK);
        Invalidate = 1'b0;
        #1;
        chk("inv_idle_miss", {31'b0, STALL_fIC}, 32'd1);
        fetch(32'h0040_0000, 1'b1);
        fetch(32'h0040_0300, 1'b1);

        Instr_address_2IC = 32'h0040_0400;
        @(negedge CLK);
        #1;
        chk("pre_reset_blkread", {31'b0, iBlkRead}, 32'd1);
        RESET = 1'b0;
        #1;
        chk("async_rst_blkread", {31'b0, iBlkRead}, 32'd0);
        chk("async_rst_hits", HitCount, 32'd0);
        chk("async_rst_misses", MissCount, 32'd0);
        chk("async_rst_stall", {31'b0, STALL_fIC}, 32'd1);
        @(negedge CLK);
        RESET = 1'b1;
        block_read_fIM = mk_block(32'h0040_0400);
        block_read_fIM_valid = 1'b1;
        @(negedge CLK);
        block_read_fIM_valid = 1'b0;
        #1;
        chk("ghost_valid_ignored", {31'b0, iBlkRead}, 32'd1);
        chk("post_rst_misses", MissCount, 32'd1);
        run_fill(32'h0040_0400, 1'b0);
        chk("post_rst_hit", {31'b0, Instr1_valid_fIC}, 32'd1);
        chk("post_rst_instr1", Instr1_fIC, mk_word(32'h0040_0400));

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
